// File: rtl/axi4_stream_slave_wrapper_if.sv
// Stream link bundle between the operand/result master and the slave wrapper.
// Both directions are named from the link's point of view (to_slave / to_master).
interface axi4_stream_slave_wrapper_if #(
    parameter int unsigned DSZ = 8
) ();

    logic [DSZ-1:0] tdata_to_slave;
    logic           tvalid_to_slave;
    logic           tready_to_slave;
    logic           tlast_to_slave;

    logic [DSZ-1:0] tdata_to_master;
    logic           tvalid_to_master;
    logic           tready_to_master;
    logic           tlast_to_master;

    modport slave (
        input  tdata_to_slave,
        input  tvalid_to_slave,
        input  tlast_to_slave,
        output tready_to_slave,
        output tdata_to_master,
        output tvalid_to_master,
        output tlast_to_master,
        input  tready_to_master
    );

    modport master (
        output tdata_to_slave,
        output tvalid_to_slave,
        output tlast_to_slave,
        input  tready_to_slave,
        input  tdata_to_master,
        input  tvalid_to_master,
        input  tlast_to_master,
        output tready_to_master
    );

endinterface

// File: rtl/axi4_stream_slave_wrapper.sv
// Slave end of the operand/result stream: assembles a/b from NB byte beats, hands them
// to the compute unit, captures the 2*SZ result and streams it back with tlast.
module axi4_stream_slave_wrapper #(
    parameter int unsigned SZ  = 32,
    parameter int unsigned DSZ = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    axi4_stream_slave_wrapper_if.slave  s,
    output logic [SZ-1:0]               a,
    output logic [SZ-1:0]               b,
    output logic                        op_valid,
    input  logic [2*SZ-1:0]             res,
    input  logic                        res_valid,
    output logic                        proto_err
);

    localparam int unsigned NB = 2 * SZ / DSZ;
    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    typedef enum logic [1:0] {
        RECV = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NB-1:0][DSZ-1:0]  buf_q, buf_d;
    logic [NB-1:0][DSZ-1:0]  res_q, res_d;
    logic [SZ-1:0]           a_d, b_d;
    logic                    op_valid_d;
    logic                    proto_err_d;
    logic                    tready_q, tready_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic [DSZ-1:0]          tdata_q, tdata_d;

    assign s.tready_to_slave  = tready_q;
    assign s.tvalid_to_master = tvalid_q;
    assign s.tlast_to_master  = tlast_q;
    assign s.tdata_to_master  = tdata_q;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RECV;
            idx_q     <= '0;
            buf_q     <= '0;
            res_q     <= '0;
            a         <= '0;
            b         <= '0;
            op_valid  <= 1'b0;
            proto_err <= 1'b0;
            tready_q  <= 1'b1;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            res_q     <= res_d;
            a         <= a_d;
            b         <= b_d;
            op_valid  <= op_valid_d;
            proto_err <= proto_err_d;
            tready_q  <= tready_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tdata_q   <= tdata_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        res_d       = res_q;
        a_d         = a;
        b_d         = b;
        op_valid_d  = 1'b0;
        proto_err_d = 1'b0;
        tready_d    = tready_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;

        unique case (state_q)
            RECV: begin
                tready_d = 1'b1;
                if (s.tvalid_to_slave && tready_q) begin
                    buf_d[idx_q] = s.tdata_to_slave;
                    if (idx_q == LAST_IDX) begin
                        // Packet complete; a missing tlast is flagged but the packet is kept
                        a_d         = buf_d[NB/2-1:0];
                        b_d         = buf_d[NB-1:NB/2];
                        op_valid_d  = 1'b1;
                        proto_err_d = ~s.tlast_to_slave;
                        idx_d       = '0;
                        tready_d    = 1'b0;
                        state_d     = CALC;
                    end else if (s.tlast_to_slave) begin
                        // Early tlast: partial staging is abandoned, a/b untouched
                        proto_err_d = 1'b1;
                        idx_d       = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end

            CALC: begin
                tready_d = 1'b0;
                // The op_valid cycle itself is excluded so a stale res_valid cannot complete
                if (res_valid && !op_valid) begin
                    res_d    = res;
                    tvalid_d = 1'b1;
                    tdata_d  = res[DSZ-1:0];
                    tlast_d  = 1'b0;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end

            SEND: begin
                tready_d = 1'b0;
                if (tvalid_q && s.tready_to_master) begin
                    if (idx_q == LAST_IDX) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        idx_d    = '0;
                        tready_d = 1'b1;
                        state_d  = RECV;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        tdata_d = res_q[idx_d];
                        tlast_d = (idx_d == LAST_IDX);
                    end
                end
            end

            default: begin
                state_d  = RECV;
                idx_d    = '0;
                tready_d = 1'b1;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_axi4_stream_slave_wrapper.sv
// Self-checking bench for axi4_stream_slave_wrapper: randomized operand/result traffic
// checked against a byte-packing model and a negedge monitor of both stream directions.
module tb_axi4_stream_slave_wrapper;

    localparam int unsigned SZ  = 32;
    localparam int unsigned DSZ = 8;
    localparam int unsigned NB  = 2 * SZ / DSZ;

    typedef logic [DSZ-1:0] byteq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi4_stream_slave_wrapper_if #(.DSZ(DSZ)) sif ();

    logic [SZ-1:0]   a, b;
    logic            op_valid, proto_err, res_valid;
    logic [2*SZ-1:0] res;

    axi4_stream_slave_wrapper #(.SZ(SZ), .DSZ(DSZ)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (sif.slave),
        .a         (a),
        .b         (b),
        .op_valid  (op_valid),
        .res       (res),
        .res_valid (res_valid),
        .proto_err (proto_err)
    );

    int checks = 0;
    int errors = 0;

    // Monitor state
    int            cyc = 0;
    int            opv_cnt = 0, perr_cnt = 0, stall_viol = 0, ovl_viol = 0;
    int            opv_cyc = 0, tv_cyc = 0;
    logic [SZ-1:0] cap_a = '0, cap_b = '0;
    logic [DSZ:0]  out_q[$];
    int            out_cyc[$];
    bit            busy = 0, prev_stall = 0, prev_tv = 0;
    logic [DSZ-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            busy = 0; prev_stall = 0; prev_tv = 0;
        end else begin
            if (busy && sif.tready_to_slave) ovl_viol++;
            if (prev_stall && (sif.tvalid_to_master !== 1'b1 || sif.tdata_to_master !== prev_data ||
                               sif.tlast_to_master !== prev_last)) stall_viol++;
            prev_stall = sif.tvalid_to_master && !sif.tready_to_master;
            prev_data  = sif.tdata_to_master;
            prev_last  = sif.tlast_to_master;
            if (op_valid === 1'b1) begin
                opv_cnt++; cap_a = a; cap_b = b; opv_cyc = cyc; busy = 1;
            end
            if (proto_err === 1'b1) perr_cnt++;
            if (sif.tvalid_to_master === 1'b1 && !prev_tv) tv_cyc = cyc;
            prev_tv = (sif.tvalid_to_master === 1'b1);
            if (sif.tvalid_to_master === 1'b1 && sif.tready_to_master) begin
                out_q.push_back({sif.tlast_to_master, sif.tdata_to_master});
                out_cyc.push_back(cyc);
                if (sif.tlast_to_master) busy = 0;
            end
        end
    end

    // Reference model: little-endian byte packing and expected result beats
    function automatic logic [2*SZ-1:0] pack_bytes(input byteq_t q);
        logic [2*SZ-1:0] v = '0;
        for (int i = 0; i < int'(NB); i++) v = v | ((2*SZ)'(q[i]) << (DSZ * i));
        return v;
    endfunction

    function automatic logic [DSZ:0] exp_beat(input logic [2*SZ-1:0] r, input int j);
        return {(j == int'(NB) - 1), r[DSZ*j +: DSZ]};
    endfunction

    function automatic byteq_t rand_bytes(input int n);
        byteq_t q;
        for (int i = 0; i < n; i++) q.push_back(DSZ'($urandom));
        return q;
    endfunction

    // Stimulus drivers (no checking); all start and end at posedge+1
    task automatic drive_packet(input byteq_t q, input int tlast_pos, input bit hold,
                                input logic [DSZ-1:0] hold_data, output int last_cyc, output bit ok);
        bit acc;
        ok = 1; last_cyc = 0;
        for (int i = 0; i < q.size(); i++) begin
            sif.tdata_to_slave  = q[i];
            sif.tlast_to_slave  = (i == tlast_pos);
            sif.tvalid_to_slave = 1'b1;
            acc = 0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                acc = (sif.tready_to_slave === 1'b1);
                if (acc) last_cyc = cyc;
                @(posedge clk); #1;
            end
            if (!acc) begin ok = 0; break; end
        end
        sif.tlast_to_slave = 1'b0;
        if (hold) sif.tdata_to_slave = hold_data;
        else      sif.tvalid_to_slave = 1'b0;
    endtask

    task automatic respond(input logic [2*SZ-1:0] r, input int delay, output bit ok);
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (op_valid === 1'b1) begin ok = 1; break; end
        end
        repeat (delay) @(posedge clk);
        #1;
        res = r; res_valid = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        res = {$urandom, $urandom};
    endtask

    task automatic collect(input int n, input int mode, output bit ok);
        for (int t = 0; t < 500; t++) begin
            case (mode)
                1:       sif.tready_to_master = ((t % 3) == 0);
                2:       sif.tready_to_master = 1'($urandom_range(0, 1));
                default: sif.tready_to_master = 1'b1;
            endcase
            @(posedge clk); #1;
            if (out_q.size() >= n) break;
        end
        sif.tready_to_master = 1'b0;
        ok = (out_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        res_valid = 1'b1;
        @(negedge clk);
        checks++; if (sif.tready_to_slave !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b expected 1", sif.tready_to_slave); end
        checks++; if (sif.tvalid_to_master !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", sif.tvalid_to_master); end
        checks++; if (sif.tdata_to_master !== '0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", sif.tdata_to_master); end
        checks++; if (sif.tlast_to_master !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", sif.tlast_to_master); end
        checks++; if ({a, b} !== '0) begin errors++; $display("FAIL reset_ab: got %h/%h expected 0/0", a, b); end
        checks++; if ({op_valid, proto_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b%b expected 00", op_valid, proto_err); end
        // res_valid outside CALC must not start a result packet
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (sif.tvalid_to_master !== 1'b0 || op_valid !== 1'b0) begin errors++; $display("FAIL idle_res_valid: got tvalid=%b op_valid=%b expected 0/0", sif.tvalid_to_master, op_valid); end
        res_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        byteq_t q = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
        logic [2*SZ-1:0] r = 64'h0000_0000_1122_3344;
        logic [2*SZ-1:0] v = pack_bytes(q);
        int opv0 = opv_cnt, perr0 = perr_cnt, lc;
        bit ok1, ok2, ok3;
        out_q.delete(); out_cyc.delete();
        drive_packet(q, 7, 0, '0, lc, ok1);
        respond(r, 2, ok2);
        collect(NB, 0, ok3);
        checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL basic_timeout: got %b%b%b expected 111", ok1, ok2, ok3); end
        checks++; if (opv_cnt - opv0 !== 1) begin errors++; $display("FAIL basic_op_valid: got %0d pulses expected 1", opv_cnt - opv0); end
        checks++; if (perr_cnt !== perr0) begin errors++; $display("FAIL basic_proto_err: got %0d expected %0d", perr_cnt, perr0); end
        checks++; if (cap_a !== v[SZ-1:0] || cap_a !== 32'h01020304) begin errors++; $display("FAIL basic_a: got %h expected %h", cap_a, v[SZ-1:0]); end
        checks++; if (cap_b !== v[2*SZ-1:SZ] || cap_b !== 32'h05060708) begin errors++; $display("FAIL basic_b: got %h expected %h", cap_b, v[2*SZ-1:SZ]); end
        checks++; if (a !== cap_a || b !== cap_b) begin errors++; $display("FAIL basic_hold: got %h/%h expected %h/%h", a, b, cap_a, cap_b); end
        checks++; if (out_q.size() !== NB) begin errors++; $display("FAIL basic_beats: got %0d expected %0d", out_q.size(), NB); end
        for (int j = 0; j < out_q.size() && j < int'(NB); j++) begin
            checks++; if (out_q[j] !== exp_beat(r, j)) begin errors++; $display("FAIL basic_beat%0d: got %h expected %h", j, out_q[j], exp_beat(r, j)); end
        end
        if (out_cyc.size() == NB) begin
            checks++; if (out_cyc[NB-1] - out_cyc[0] !== int'(NB) - 1) begin errors++; $display("FAIL basic_rate: got span %0d expected %0d", out_cyc[NB-1] - out_cyc[0], NB - 1); end
        end
    endtask

    task automatic test_latency();
        byteq_t q = rand_bytes(NB);
        logic [2*SZ-1:0] r = {$urandom, $urandom};
        int lc;
        bit ok1, ok3;
        out_q.delete(); out_cyc.delete();
        res = r; res_valid = 1'b1;
        drive_packet(q, NB - 1, 0, '0, lc, ok1);
        collect(NB, 0, ok3);
        res_valid = 1'b0;
        checks++; if (!(ok1 && ok3)) begin errors++; $display("FAIL latency_timeout: got %b%b expected 11", ok1, ok3); end
        checks++; if (opv_cyc - lc !== 1) begin errors++; $display("FAIL latency_op_valid: got +%0d expected +1", opv_cyc - lc); end
        checks++; if (tv_cyc - lc !== 3) begin errors++; $display("FAIL latency_beat0: got +%0d expected +3", tv_cyc - lc); end
        for (int j = 0; j < out_q.size() && j < int'(NB); j++) begin
            checks++; if (out_q[j] !== exp_beat(r, j)) begin errors++; $display("FAIL latency_beat%0d: got %h expected %h", j, out_q[j], exp_beat(r, j)); end
        end
    endtask

    task automatic test_stall();
        byteq_t q = rand_bytes(NB);
        logic [2*SZ-1:0] r = {$urandom, $urandom};
        int sv0 = stall_viol, lc;
        bit ok1, ok2, ok3;
        out_q.delete(); out_cyc.delete();
        drive_packet(q, NB - 1, 0, '0, lc, ok1);
        respond(r, $urandom_range(1, 4), ok2);
        collect(NB, 1, ok3);
        repeat (4) @(posedge clk); #1;
        checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL stall_timeout: got %b%b%b expected 111", ok1, ok2, ok3); end
        checks++; if (stall_viol !== sv0) begin errors++; $display("FAIL stall_stable: got %0d violations expected 0", stall_viol - sv0); end
        checks++; if (out_q.size() !== NB) begin errors++; $display("FAIL stall_beats: got %0d expected %0d", out_q.size(), NB); end
        for (int j = 0; j < out_q.size() && j < int'(NB); j++) begin
            checks++; if (out_q[j] !== exp_beat(r, j)) begin errors++; $display("FAIL stall_beat%0d: got %h expected %h", j, out_q[j], exp_beat(r, j)); end
        end
    endtask

    task automatic test_early_tlast();
        byteq_t part = rand_bytes(4);
        byteq_t q = rand_bytes(NB);
        logic [2*SZ-1:0] v = pack_bytes(q);
        logic [2*SZ-1:0] r = {$urandom, $urandom};
        logic [SZ-1:0] a0 = a, b0 = b;
        int opv0 = opv_cnt, perr0 = perr_cnt, lc;
        bit ok1, ok2, ok3;
        drive_packet(part, 3, 0, '0, lc, ok1);
        repeat (3) @(posedge clk); #1;
        checks++; if (perr_cnt - perr0 !== 1) begin errors++; $display("FAIL early_proto_err: got %0d pulses expected 1", perr_cnt - perr0); end
        checks++; if (opv_cnt !== opv0) begin errors++; $display("FAIL early_op_valid: got %0d pulses expected 0", opv_cnt - opv0); end
        checks++; if (a !== a0 || b !== b0) begin errors++; $display("FAIL early_ab_kept: got %h/%h expected %h/%h", a, b, a0, b0); end
        out_q.delete(); out_cyc.delete();
        drive_packet(q, NB - 1, 0, '0, lc, ok2);
        respond(r, 1, ok3);
        checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL early_timeout: got %b%b%b expected 111", ok1, ok2, ok3); end
        checks++; if (cap_a !== v[SZ-1:0] || cap_b !== v[2*SZ-1:SZ]) begin errors++; $display("FAIL early_next_ab: got %h/%h expected %h/%h", cap_a, cap_b, v[SZ-1:0], v[2*SZ-1:SZ]); end
        collect(NB, 0, ok3);
        checks++; if (out_q.size() !== NB || out_q[NB-1] !== exp_beat(r, NB - 1)) begin errors++; $display("FAIL early_result: got %0d beats expected %0d", out_q.size(), NB); end
    endtask

    task automatic test_missing_tlast();
        byteq_t q = rand_bytes(NB);
        logic [2*SZ-1:0] v = pack_bytes(q);
        logic [2*SZ-1:0] r = {$urandom, $urandom};
        int opv0 = opv_cnt, perr0 = perr_cnt, lc;
        bit ok1, ok2, ok3;
        out_q.delete(); out_cyc.delete();
        drive_packet(q, -1, 0, '0, lc, ok1);
        respond(r, 3, ok2);
        collect(NB, 2, ok3);
        checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL notlast_timeout: got %b%b%b expected 111", ok1, ok2, ok3); end
        checks++; if (perr_cnt - perr0 !== 1 || opv_cnt - opv0 !== 1) begin errors++; $display("FAIL notlast_pulses: got perr=%0d opv=%0d expected 1/1", perr_cnt - perr0, opv_cnt - opv0); end
        checks++; if (cap_a !== v[SZ-1:0] || cap_b !== v[2*SZ-1:SZ]) begin errors++; $display("FAIL notlast_ab: got %h/%h expected %h/%h", cap_a, cap_b, v[SZ-1:0], v[2*SZ-1:SZ]); end
        for (int j = 0; j < out_q.size() && j < int'(NB); j++) begin
            checks++; if (out_q[j] !== exp_beat(r, j)) begin errors++; $display("FAIL notlast_beat%0d: got %h expected %h", j, out_q[j], exp_beat(r, j)); end
        end
    endtask

    task automatic test_mid_reset();
        byteq_t q = rand_bytes(NB);
        logic [2*SZ-1:0] r = {$urandom, $urandom};
        int lc;
        bit ok1, ok2, ok3;
        out_q.delete(); out_cyc.delete();
        drive_packet(q, NB - 1, 0, '0, lc, ok1);
        respond(r, 1, ok2);
        collect(4, 0, ok3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL midrst_timeout: got %b%b%b expected 111", ok1, ok2, ok3); end
        checks++; if (sif.tvalid_to_master !== 1'b0 || sif.tlast_to_master !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b/%b expected 0/0", sif.tvalid_to_master, sif.tlast_to_master); end
        checks++; if (sif.tready_to_slave !== 1'b1) begin errors++; $display("FAIL midrst_tready: got %b expected 1", sif.tready_to_slave); end
        checks++; if (a !== '0 || b !== '0) begin errors++; $display("FAIL midrst_ab: got %h/%h expected 0/0", a, b); end
        repeat (3) @(posedge clk); #1;
        checks++; if (out_q.size() !== 4) begin errors++; $display("FAIL midrst_partial: got %0d beats expected 4", out_q.size()); end
        q = rand_bytes(NB);
        r = {$urandom, $urandom};
        out_q.delete(); out_cyc.delete();
        drive_packet(q, NB - 1, 0, '0, lc, ok1);
        respond(r, 2, ok2);
        collect(NB, 0, ok3);
        checks++; if (!(ok1 && ok2 && ok3) || pack_bytes(q) !== {cap_b, cap_a}) begin errors++; $display("FAIL midrst_fresh_ab: got %h%h expected %h", cap_b, cap_a, pack_bytes(q)); end
        for (int j = 0; j < out_q.size() && j < int'(NB); j++) begin
            checks++; if (out_q[j] !== exp_beat(r, j)) begin errors++; $display("FAIL midrst_beat%0d: got %h expected %h", j, out_q[j], exp_beat(r, j)); end
        end
    endtask

    task automatic test_back_to_back();
        byteq_t pk[4];
        logic [2*SZ-1:0] r;
        int ov0 = ovl_viol, sv0 = stall_viol, lc;
        bit ok1, ok2, ok3;
        for (int p = 0; p < 4; p++) pk[p] = rand_bytes(NB);
        for (int p = 0; p < 4; p++) begin
            r = {$urandom, $urandom};
            out_q.delete(); out_cyc.delete();
            drive_packet(pk[p], NB - 1, p < 3, (p < 3) ? pk[(p + 1) % 4][0] : 8'h00, lc, ok1);
            respond(r, $urandom_range(1, 5), ok2);
            collect(NB, 2, ok3);
            checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL b2b%0d_timeout: got %b%b%b expected 111", p, ok1, ok2, ok3); end
            checks++; if ({cap_b, cap_a} !== pack_bytes(pk[p])) begin errors++; $display("FAIL b2b%0d_ab: got %h%h expected %h", p, cap_b, cap_a, pack_bytes(pk[p])); end
            for (int j = 0; j < out_q.size() && j < int'(NB); j++) begin
                checks++; if (out_q[j] !== exp_beat(r, j)) begin errors++; $display("FAIL b2b%0d_beat%0d: got %h expected %h", p, j, out_q[j], exp_beat(r, j)); end
            end
        end
        checks++; if (ovl_viol !== ov0) begin errors++; $display("FAIL b2b_overlap: got %0d ready cycles while busy expected 0", ovl_viol - ov0); end
        checks++; if (stall_viol !== sv0) begin errors++; $display("FAIL b2b_stable: got %0d violations expected 0", stall_viol - sv0); end
    endtask

    initial begin
        rst = 1'b1;
        res = '0;
        res_valid = 1'b0;
        sif.tdata_to_slave   = '0;
        sif.tvalid_to_slave  = 1'b0;
        sif.tlast_to_slave   = 1'b0;
        sif.tready_to_master = 1'b0;
        test_reset();
        test_basic();
        test_latency();
        test_stall();
        test_early_tlast();
        test_missing_tlast();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
